// File: rtl/battle_turn_scheduler_if.sv
// Scheduler bus: decode/AI strobes, engine health bars,
// strike strobes, attack choices and battle status.
interface battle_turn_scheduler_if;
  logic       collision_detected;
  logic       player_valid;
  logic [1:0] player_key;
  logic       enemy_valid;
  logic [1:0] enemy_key;
  logic [7:0] player_HB;
  logic [7:0] enemy_HB;
  logic       player_turn;
  logic       attacker_turn;
  logic [1:0] player_choice;
  logic [1:0] enemy_choice;
  logic       battle_active;
  logic [4:0] round;
  logic       timeout_pulse;
  logic       player_win;
  logic       enemy_win;
  logic       draw;

  modport master (
    output collision_detected,
    output player_valid,
    output player_key,
    output enemy_valid,
    output enemy_key,
    output player_HB,
    output enemy_HB,
    input  player_turn,
    input  attacker_turn,
    input  player_choice,
    input  enemy_choice,
    input  battle_active,
    input  round,
    input  timeout_pulse,
    input  player_win,
    input  enemy_win,
    input  draw
  );

  modport slave (
    input  collision_detected,
    input  player_valid,
    input  player_key,
    input  enemy_valid,
    input  enemy_key,
    input  player_HB,
    input  enemy_HB,
    output player_turn,
    output attacker_turn,
    output player_choice,
    output enemy_choice,
    output battle_active,
    output round,
    output timeout_pulse,
    output player_win,
    output enemy_win,
    output draw
  );
endinterface

// File: rtl/battle_turn_scheduler.sv
// Turn sequencer between key/AI decode and the attack engine.
// Optional ENEMY_AUTO_EN: enemy choice comes from an internal LFSR.
module battle_turn_scheduler #(
  parameter int TURN_TIMEOUT  = 255,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_ROUNDS    = 20,
  parameter int PLAYER_FIRST  = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  battle_turn_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    P_WAIT,
    P_STRIKE,
    P_SETTLE,
    E_WAIT,
    E_STRIKE,
    E_SETTLE,
    DONE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TURN_TIMEOUT - 1);
  localparam logic [7:0] SE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [4:0] R_MAX   = 5'(MAX_ROUNDS);
  localparam bit         P_FIRST = (PLAYER_FIRST != 0);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [7:0] r_hb_prev;
  logic [1:0] r_p_choice;
  logic [1:0] r_e_choice;
  logic [4:0] r_round;
  logic       r_p_win;
  logic       r_e_win;
  logic       r_draw;

  logic       w_p_ld;
  logic [1:0] w_p_key;
  logic       w_e_ld;
  logic [1:0] w_e_key;
  logic       w_to;
  logic       w_set_pwin;
  logic       w_set_ewin;
  logic       w_set_draw;
  logic       w_round_inc;
  logic [4:0] w_round_nx;
  logic       w_settled;
  logic       w_p_ko;
  logic       w_e_ko;

`ifdef ENEMY_AUTO_EN
  logic [7:0] r_lfsr;
  logic       w_unused;

  assign w_unused = ^{bus.enemy_valid, bus.enemy_key};

  // x^8+x^6+x^5+x^4+1, free-running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 8'hA5;
    else r_lfsr <= {r_lfsr[6:0],
                    r_lfsr[7] ^ r_lfsr[5] ^
                    r_lfsr[4] ^ r_lfsr[3]};
  end
`endif

  assign w_round_nx = r_round + 5'd1;
  assign w_settled  = (r_cnt == SE_LAST);
  // a bar that went up after a strike has wrapped below zero
  assign w_p_ko = (bus.enemy_HB == 8'd0) ||
                  (bus.enemy_HB > r_hb_prev);
  assign w_e_ko = (bus.player_HB == 8'd0) ||
                  (bus.player_HB > r_hb_prev);

  always_comb begin
    w_next      = r_state;
    w_p_ld      = 1'b0;
    w_p_key     = 2'b00;
    w_e_ld      = 1'b0;
    w_e_key     = 2'b00;
    w_to        = 1'b0;
    w_set_pwin  = 1'b0;
    w_set_ewin  = 1'b0;
    w_set_draw  = 1'b0;
    w_round_inc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.collision_detected)
          w_next = P_FIRST ? P_WAIT : E_WAIT;
      end
      P_WAIT: begin
        if (bus.player_valid) begin
          w_p_ld  = 1'b1;
          w_p_key = bus.player_key;
          w_next  = P_STRIKE;
        end else if (r_cnt == TO_LAST) begin
          w_p_ld = 1'b1;
          w_to   = 1'b1;
          w_next = P_STRIKE;
        end
      end
      P_STRIKE: w_next = P_SETTLE;
      P_SETTLE: begin
        if (w_settled) begin
          if (w_p_ko) begin
            w_set_pwin = 1'b1;
            w_next     = DONE;
          end else begin
            w_next = E_WAIT;
            if (!P_FIRST) begin
              w_round_inc = 1'b1;
              if (w_round_nx == R_MAX) begin
                w_set_draw = 1'b1;
                w_next     = DONE;
              end
            end
          end
        end
      end
      E_WAIT: begin
`ifdef ENEMY_AUTO_EN
        w_e_ld  = 1'b1;
        w_e_key = r_lfsr[1:0];
        w_next  = E_STRIKE;
`else
        if (bus.enemy_valid) begin
          w_e_ld  = 1'b1;
          w_e_key = bus.enemy_key;
          w_next  = E_STRIKE;
        end else if (r_cnt == TO_LAST) begin
          w_e_ld = 1'b1;
          w_to   = 1'b1;
          w_next = E_STRIKE;
        end
`endif
      end
      E_STRIKE: w_next = E_SETTLE;
      E_SETTLE: begin
        if (w_settled) begin
          if (w_e_ko) begin
            w_set_ewin = 1'b1;
            w_next     = DONE;
          end else begin
            w_next = P_WAIT;
            if (P_FIRST) begin
              w_round_inc = 1'b1;
              if (w_round_nx == R_MAX) begin
                w_set_draw = 1'b1;
                w_next     = DONE;
              end
            end
          end
        end
      end
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_hb_prev  <= 8'd0;
      r_p_choice <= 2'b00;
      r_e_choice <= 2'b00;
      r_round    <= 5'd0;
      r_p_win    <= 1'b0;
      r_e_win    <= 1'b0;
      r_draw     <= 1'b0;
    end else begin
      r_state <= w_next;
      // one counter serves both WAIT timeout and SETTLE delay
      if (w_next != r_state || r_state == IDLE ||
          r_state == DONE)
        r_cnt <= 8'd0;
      else
        r_cnt <= r_cnt + 8'd1;
      if (w_p_ld) r_p_choice <= w_p_key;
      if (w_e_ld) r_e_choice <= w_e_key;
      if (r_state == P_STRIKE)
        r_hb_prev <= bus.enemy_HB;
      else if (r_state == E_STRIKE)
        r_hb_prev <= bus.player_HB;
      if (w_round_inc) r_round <= w_round_nx;
      if (w_set_pwin) r_p_win <= 1'b1;
      if (w_set_ewin) r_e_win <= 1'b1;
      if (w_set_draw) r_draw  <= 1'b1;
    end
  end

  assign bus.player_turn   = (r_state == P_STRIKE);
  assign bus.attacker_turn = (r_state == E_STRIKE);
  assign bus.player_choice = r_p_choice;
  assign bus.enemy_choice  = r_e_choice;
  assign bus.battle_active = (r_state != IDLE) &&
                             (r_state != DONE);
  assign bus.round         = r_round;
  assign bus.timeout_pulse = w_to;
  assign bus.player_win    = r_p_win;
  assign bus.enemy_win     = r_e_win;
  assign bus.draw          = r_draw;

endmodule

// File: tb/tb_battle_turn_scheduler.sv
// Bench for battle_turn_scheduler: directed turn table, random
// battles against a turn-level model, and a mid-battle reset.
module tb_battle_turn_scheduler;
  localparam int TO = 8;
  localparam int SC = 2;
  localparam int MR = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  battle_turn_scheduler_if bus ();

  battle_turn_scheduler #(
    .TURN_TIMEOUT (TO),
    .SETTLE_CYCLES(SC),
    .MAX_ROUNDS   (MR),
    .PLAYER_FIRST (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit         new_battle;
    logic [7:0] hp;
    logic [7:0] he;
    bit         side_e;
    int         d;
    logic [1:0] key;
    logic [7:0] dmg;
    bit         exp_to;
    logic [1:0] exp_ch;
    int         exp_end;
  } vec_t;

  vec_t       tbl[9];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] e_pch;
  logic [1:0] e_ech;
  int         e_round;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pturn"}, bus.player_turn, 0);
    chk({tag, "_aturn"}, bus.attacker_turn, 0);
    chk({tag, "_pch"}, bus.player_choice, 0);
    chk({tag, "_ech"}, bus.enemy_choice, 0);
    chk({tag, "_active"}, bus.battle_active, 0);
    chk({tag, "_round"}, bus.round, 0);
    chk({tag, "_to"}, bus.timeout_pulse, 0);
    chk({tag, "_pwin"}, bus.player_win, 0);
    chk({tag, "_ewin"}, bus.enemy_win, 0);
    chk({tag, "_draw"}, bus.draw, 0);
  endtask

  task automatic idle_inputs();
    bus.player_valid = 1'b0;
    bus.enemy_valid  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.collision_detected = 1'b0;
    idle_inputs();
    #1;
    chk_zero(tag);
    e_pch   = 2'b00;
    e_ech   = 2'b00;
    e_round = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic launch();
    @(negedge clk);
    chk("idle_active", bus.battle_active, 0);
    @(posedge clk);
    #1 bus.collision_detected = 1'b1;
    @(negedge clk);
    chk("pre_start_active", bus.battle_active, 0);
    @(posedge clk);
    #1 bus.collision_detected = 1'($urandom_range(0, 1));
  endtask

  task automatic start_battle(input logic [7:0] hp,
                              input logic [7:0] he);
    do_reset("rst");
    bus.player_HB = hp;
    bus.enemy_HB  = he;
    launch();
  endtask

  task automatic do_turn(input bit side_e, input int d,
                         input logic [1:0] key,
                         input logic [7:0] dmg,
                         input bit exp_to,
                         input logic [1:0] exp_ch,
                         input int exp_end,
                         input bit abort);
    for (int k = 0; k < TO; k++) begin
      if (k == d) begin
        if (side_e) begin
          bus.enemy_valid = 1'b1;
          bus.enemy_key   = key;
        end else begin
          bus.player_valid = 1'b1;
          bus.player_key   = key;
        end
      end
      // the other side's strobe must be dropped
      if (side_e) begin
        bus.player_valid = 1'($urandom_range(0, 1));
        bus.player_key   = 2'($urandom);
      end else begin
        bus.enemy_valid = 1'($urandom_range(0, 1));
        bus.enemy_key   = 2'($urandom);
      end
      @(negedge clk);
      chk("wait_pturn", bus.player_turn, 0);
      chk("wait_aturn", bus.attacker_turn, 0);
      chk("wait_to", bus.timeout_pulse,
          (exp_to && k == TO - 1) ? 1 : 0);
      chk("wait_active", bus.battle_active, 1);
      chk("wait_round", bus.round, e_round);
      chk("wait_pch", bus.player_choice, e_pch);
      chk("wait_ech", bus.enemy_choice, e_ech);
      @(posedge clk);
      #1 idle_inputs();
      if (k == d || k == TO - 1) break;
    end
    if (side_e) e_ech = exp_ch;
    else e_pch = exp_ch;
    @(negedge clk);
    chk("strike_pturn", bus.player_turn, side_e ? 0 : 1);
    chk("strike_aturn", bus.attacker_turn, side_e ? 1 : 0);
    chk("strike_to", bus.timeout_pulse, 0);
    chk("strike_pch", bus.player_choice, e_pch);
    chk("strike_ech", bus.enemy_choice, e_ech);
    @(posedge clk);
    #1;
    if (side_e) bus.player_HB = bus.player_HB - dmg;
    else bus.enemy_HB = bus.enemy_HB - dmg;
    if (abort) return;
    for (int s = 0; s < SC; s++) begin
      bus.player_valid = 1'($urandom_range(0, 1));
      bus.enemy_valid  = 1'($urandom_range(0, 1));
      bus.player_key   = 2'($urandom);
      bus.enemy_key    = 2'($urandom);
      @(negedge clk);
      chk("settle_pturn", bus.player_turn, 0);
      chk("settle_aturn", bus.attacker_turn, 0);
      chk("settle_to", bus.timeout_pulse, 0);
      chk("settle_active", bus.battle_active, 1);
      @(posedge clk);
      #1 idle_inputs();
    end
    if (side_e && (exp_end == 0 || exp_end == 3))
      e_round++;
    if (exp_end != 0) begin
      for (int c = 0; c < 4; c++) begin
        bus.player_valid       = 1'b1;
        bus.enemy_valid        = 1'b1;
        bus.collision_detected = 1'b1;
        @(negedge clk);
        chk("done_active", bus.battle_active, 0);
        chk("done_pturn", bus.player_turn, 0);
        chk("done_aturn", bus.attacker_turn, 0);
        chk("done_to", bus.timeout_pulse, 0);
        chk("done_pwin", bus.player_win,
            (exp_end == 1) ? 1 : 0);
        chk("done_ewin", bus.enemy_win,
            (exp_end == 2) ? 1 : 0);
        chk("done_draw", bus.draw, (exp_end == 3) ? 1 : 0);
        chk("done_round", bus.round, e_round);
        chk("done_pch", bus.player_choice, e_pch);
        chk("done_ech", bus.enemy_choice, e_ech);
        @(posedge clk);
        #1 idle_inputs();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.collision_detected = 1'b0;
    bus.player_valid       = 1'b0;
    bus.enemy_valid        = 1'b0;
    bus.player_key         = 2'b00;
    bus.enemy_key          = 2'b00;
    bus.player_HB          = 8'd0;
    bus.enemy_HB           = 8'd0;

    // side_e 1 = enemy turn; d >= TO = no valid; end 1/2/3
    // = player win / enemy win / draw
    tbl[0] = '{1'b1, 8'd100, 8'd20, 1'b0, 0, 2'b01,
               8'd0, 1'b0, 2'b01, 0};
    tbl[1] = '{1'b0, 8'd0, 8'd0, 1'b1, 2, 2'b11,
               8'd10, 1'b0, 2'b11, 0};
    tbl[2] = '{1'b0, 8'd0, 8'd0, 1'b0, 7, 2'b10,
               8'd28, 1'b0, 2'b10, 1};
    tbl[3] = '{1'b1, 8'd50, 8'd50, 1'b0, 99, 2'b11,
               8'd5, 1'b1, 2'b00, 0};
    tbl[4] = '{1'b0, 8'd0, 8'd0, 1'b1, 99, 2'b10,
               8'd5, 1'b1, 2'b00, 0};
    tbl[5] = '{1'b0, 8'd0, 8'd0, 1'b0, 4, 2'b11,
               8'd5, 1'b0, 2'b11, 0};
    tbl[6] = '{1'b0, 8'd0, 8'd0, 1'b1, 1, 2'b01,
               8'd5, 1'b0, 2'b01, 3};
    tbl[7] = '{1'b1, 8'd30, 8'd200, 1'b0, 3, 2'b00,
               8'd1, 1'b0, 2'b00, 0};
    tbl[8] = '{1'b0, 8'd0, 8'd0, 1'b1, 0, 2'b10,
               8'd30, 1'b0, 2'b10, 2};

    #2;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].new_battle)
        start_battle(tbl[i].hp, tbl[i].he);
      do_turn(tbl[i].side_e, tbl[i].d, tbl[i].key,
              tbl[i].dmg, tbl[i].exp_to, tbl[i].exp_ch,
              tbl[i].exp_end, 1'b0);
    end

    // random battles against a turn-level model
    for (int b = 0; b < 30; b++) begin
      bit side_e;
      int rounds;
      start_battle(8'($urandom_range(1, 255)),
                   8'($urandom_range(1, 255)));
      side_e = 1'b0;
      rounds = 0;
      for (int t = 0; t < 2 * MR; t++) begin
        int         d;
        int         hp_left;
        int         end_code;
        logic [1:0] key;
        logic [7:0] dmg;
        bit         to;
        d   = $urandom_range(0, 10);
        key = 2'($urandom);
        if ($urandom_range(0, 3) == 0)
          dmg = 8'($urandom_range(0, 255));
        else
          dmg = 8'($urandom_range(0, 30));
        hp_left = side_e ? int'(bus.player_HB) - int'(dmg)
                         : int'(bus.enemy_HB) - int'(dmg);
        to = (d >= TO);
        end_code = 0;
        if (hp_left <= 0) begin
          end_code = side_e ? 2 : 1;
        end else if (side_e) begin
          rounds++;
          if (rounds == MR) end_code = 3;
        end
        do_turn(side_e, d, key, dmg, to,
                to ? 2'b00 : key, end_code, 1'b0);
        if (end_code != 0) break;
        side_e = ~side_e;
      end
    end

    // reset pulse inside the enemy's settle window
    start_battle(8'd100, 8'd100);
    do_turn(1'b0, 0, 2'b01, 8'd1, 1'b0, 2'b01, 0, 1'b0);
    do_turn(1'b1, 1, 2'b10, 8'd1, 1'b0, 2'b10, 0, 1'b0);
    do_turn(1'b0, 2, 2'b11, 8'd1, 1'b0, 2'b11, 0, 1'b0);
    do_turn(1'b1, 0, 2'b01, 8'd1, 1'b0, 2'b01, 0, 1'b1);
    #2;
    do_reset("midrst");
    launch();
    do_turn(1'b0, 0, 2'b10, 8'd1, 1'b0, 2'b10, 0, 1'b0);
    do_turn(1'b1, 5, 2'b11, 8'd1, 1'b0, 2'b11, 0, 1'b0);
    @(negedge clk);
    chk("restart_round", bus.round, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/battle_turn_scheduler.md
Name: battle_turn_scheduler

Overview:
- Sequences a battle between the player and the enemy by driving the attack engine's per-turn strike strobes and choice buses.
- Starts on a collision, alternates turns, and waits for each health-bar update to settle before moving on.
- Detects a KO, including 8-bit health-bar underflow, and raises the win/draw flags.
- Sits between the keyboard/enemy-AI decode and the attack engine (health bars, weapon counts).

Parameters:
- TURN_TIMEOUT, 255: cycles allowed in a WAIT state before a default punch (2'b00) is forced; legal range 1..255.
- SETTLE_CYCLES, 2: cycles spent in SETTLE after a strike before the health bar is sampled; legal range 1..7.
- MAX_ROUNDS, 20: completed rounds (player turn + enemy turn) before the battle is declared a draw; legal range 1..31.
- PLAYER_FIRST, 1: 1 = player strikes first; 0 = enemy strikes first.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- collision_detected  in  1  level; starts the battle from IDLE
- player_valid  in  1  one-cycle strobe: player key pressed
- player_key  in  2  attack type (P=00, K=01, S=10, B=11)
- enemy_valid  in  1  one-cycle strobe: enemy choice ready
- enemy_key  in  2  enemy attack type
- player_HB  in  8  player health bar from the engine
- enemy_HB  in  8  enemy health bar from the engine
- player_turn  out  1  one-cycle strike strobe to the engine (player attacks)
- attacker_turn  out  1  one-cycle strike strobe to the engine (enemy attacks)
- player_choice  out  2  registered player attack type; held stable from strike until the next strike
- enemy_choice  out  2  registered enemy attack type; held the same way
- battle_active  out  1  high from battle start until DONE
- round  out  5  completed rounds
- timeout_pulse  out  1  one-cycle pulse when a default punch is forced
- player_win  out  1  sticky
- enemy_win  out  1  sticky
- draw  out  1  sticky

Behaviour:
- Reset (async): state goes to IDLE. All outputs reset to 0: player_choice and enemy_choice = 00, round = 0, timeout counter = 0. A reset mid-battle aborts the battle immediately.
- States: IDLE, P_WAIT, P_STRIKE, P_SETTLE, E_WAIT, E_STRIKE, E_SETTLE, DONE.
- IDLE: on a clk edge with collision_detected=1, set battle_active=1 and go to P_WAIT (PLAYER_FIRST=1) or E_WAIT (PLAYER_FIRST=0). After the battle starts, collision_detected is ignored.
- P_WAIT:
  - The timeout counter increments each cycle.
  - On player_valid: latch player_key into player_choice, go to P_STRIKE.
  - If the counter reaches TURN_TIMEOUT-1 with no valid: player_choice = 00, timeout_pulse = 1 for one cycle, go to P_STRIKE.
  - If player_valid and timeout land in the same cycle, player_valid wins and no timeout_pulse is raised.
  - The counter clears on leaving the state.
- P_STRIKE: exactly one cycle.
  - player_turn = 1.
  - Snapshot enemy_HB into hb_prev.
  - Go to P_SETTLE.
- P_SETTLE: wait SETTLE_CYCLES, then sample enemy_HB.
  - KO condition: enemy_HB == 0 OR enemy_HB > hb_prev (underflow wrap).
  - On KO: set player_win = 1 and go to DONE.
  - Otherwise go to E_WAIT.
- E_WAIT / E_STRIKE / E_SETTLE: mirror the player states using enemy_valid/enemy_key, attacker_turn and player_HB. On KO, set enemy_win = 1.
- Round counting: round increments when the second turn of a pair settles without a KO (i.e. on leaving E_SETTLE when PLAYER_FIRST=1, or P_SETTLE when PLAYER_FIRST=0).
  - If the incremented value equals MAX_ROUNDS: set draw = 1 and go to DONE.
  - Otherwise continue to the next turn.
- A strike strobe is never asserted in any state other than its STRIKE state. player_turn and attacker_turn are never high in the same cycle.
- valid strobes arriving outside the matching WAIT state are dropped; there is no queueing.
- DONE: battle_active = 0. The win/draw flags hold until rst_n; no further strobes are issued.
- Latency: a valid strobe in cycle N gives the strike strobe in cycle N+1. The next WAIT state is entered in cycle N+2+SETTLE_CYCLES.

Optional Feature:
- Macro: ENEMY_AUTO_EN.
- Defined: enemy_valid and enemy_key are ignored.
  - An internal 8-bit LFSR (polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advancing every cycle) supplies enemy_choice = lfsr[1:0].
  - The LFSR value is taken on the first cycle of E_WAIT, and the FSM goes straight to E_STRIKE.
  - The timeout never fires for the enemy.
- Undefined: E_WAIT behaves as described under Behaviour.

Test Plan:
- Start, player first: rst_n low then high, collision_detected=1, player_valid with key 01 -> player_turn high for exactly 1 cycle, one cycle after the valid; player_choice=01; attacker_turn stays 0.
- Timeout: TURN_TIMEOUT=8, no player_valid -> timeout_pulse at the 8th P_WAIT cycle; player_turn on the next cycle with player_choice=00.
- KO by underflow: hb_prev enemy_HB=20, engine updates it to 248 -> after SETTLE_CYCLES, player_win=1, battle_active=0, no further strobes.
- Draw: MAX_ROUNDS=2, health bars never reach 0 -> round reaches 2, draw=1, both win flags 0.
- Simultaneous timeout and valid: player_valid (key 10) in the TURN_TIMEOUT-1 cycle -> player_choice=10, timeout_pulse stays 0.
- Reset mid-operation: rst_n pulsed low during E_SETTLE -> all outputs 0 asynchronously, state IDLE; a new collision restarts the battle with round=0.
